mixer_vol_ramp: RTL and testbench
=================================

# mixer_vol_ramp

- Per-channel volume controller for the mixer.
- Holds a programmable target gain per input channel and slews the live gain toward it by a fixed step, once per sample tick, so volume changes do not click.
- Drives the mixer's flat `vol_i` bus directly.
- Uses one time-multiplexed step unit, scanning the channels one per clock.

## Interface
Parameters:
- `NUM_CH`, 8, number of mixer input channels
- `NUM_CH_LOG2`, 3, log2 of `NUM_CH`
- `VOL_WIDTH`, 32, gain width; unsigned 8.24 fixed point, 32'h01_000000 = unity
- `STEP`, 32'h0000_1000, slew per tick, unsigned, nonzero
- `RESET_VOL`, 32'h01_000000, reset value of every target and live gain

Ports:
- `clk`  in  1  49.152 MHz system clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_i`  in  1  target write strobe, single cycle
- `wr_ch_i`  in  NUM_CH_LOG2  channel addressed by the write
- `wr_vol_i`  in  VOL_WIDTH  new target gain
- `wr_ack_o`  out  1  pulses one cycle after each accepted write
- `tick_i`  in  1  sample tick, one-cycle pulse (mixer `ack_o[0]`)
- `mute_i`  in  NUM_CH  soft-mute request per channel; see Configuration
- `vol_o`  out  NUM_CH*VOL_WIDTH  live gains; channel k at `[k*VOL_WIDTH +: VOL_WIDTH]`
- `settled_o`  out  NUM_CH  bit k high when live gain k equals effective target k
- `busy_o`  out  1  high while a scan is in progress

## Operation
- Storage per channel: `tgt[k]` and `cur[k]`.
  - `vol_o` is `cur` registered directly, with no extra logic on the output.
- Writes:
  - `wr_i` is accepted every cycle, in any state, and writes `tgt[wr_ch_i] <= wr_vol_i`.
  - Writes never touch `cur`. Back-to-back writes to the same channel: the last one wins.
- Effective target `eff[k]` is `tgt[k]`, or 0 when the mute feature applies.
- FSM states: `IDLE`, `SCAN`.
  - `IDLE`, `tick_i`=1: go to `SCAN` with channel counter `ch` = 0.
  - `SCAN`: each cycle, update `cur[ch]` and increment `ch`. After `ch` = NUM_CH-1, return to `IDLE`, or restart at `ch` = 0 if a tick is pending.
- Pending tick:
  - A `tick_i` seen during `SCAN`, including the final cycle, sets a 1-bit pending flag.
  - Any further ticks before the restart are dropped; at most one is queued.
  - The flag clears when the rescan starts.
- Step rule, computed at VOL_WIDTH+1 bits so there is no wrap:
  - `cur` < `eff`: `cur` <= min(`cur`+`STEP`, `eff`).
  - `cur` > `eff`: `cur` <= max(`cur`-`STEP`, `eff`); the subtraction never underflows below `eff`.
  - Equal: no change.
- A write to channel k in the same cycle that the scan updates k: the scan uses the old `tgt[k]`; the new value takes effect on the next tick.
- `settled_o` is combinational compare of `cur` and `eff`.
- Reset behaviour:
  - Every `tgt` and `cur` goes to `RESET_VOL` and the FSM goes to `IDLE`.
  - `ch`=0, pending=0, `wr_ack_o`=0, `busy_o`=0, `settled_o`=all ones.
  - A reset mid-scan abandons the scan immediately.

## Timing
- Tick at cycle t in `IDLE`:
  - `busy_o` is high for cycles t+1 … t+NUM_CH.
  - `cur[k]` is updated at the edge ending cycle t+1+k, so the new value is visible on `vol_o` from t+2+k.
- Each channel changes at most once per tick, by at most `STEP`.
- `wr_ack_o` is high at t+1 for a write at t. The new `tgt` is visible to `settled_o` at t+1.
- Scan length must be shorter than the tick period. With 8 channels and the mixer's 48 kHz period of ~1024 clocks, the pending flag is normally unused.

## Configuration
- `MIXER_VOL_RAMP_SOFTMUTE_EN` defined:
  - `eff[k]` = `mute_i[k]` ? 0 : `tgt[k]`.
  - Mute ramps down at `STEP` per tick.
  - Unmute ramps back to the stored `tgt` without a rewrite.
- Undefined: `mute_i` is present but ignored, and `eff` = `tgt`.

## Structure
- Shared package `mixer_pkg`:
  - FSM state enum.
  - `VOL_UNITY` (32'h01_000000).
  - Default `STEP`.
- One sub-module, `vol_step`: combinational, takes `cur`, `eff` and `STEP` and returns the clamped next value. It is instantiated once and shared by the scan.

## Test plan
Tests use STEP=32'h0040_0000 and RESET_VOL=32'h0100_0000.
- Ramp down: write ch2 target 0, then send 4 ticks → `cur[2]` = 00C0_0000, 0080_0000, 0040_0000, 0000_0000. A 5th tick leaves it 0. `settled_o[2]` goes high after the 4th; other channels stay at 0100_0000.
- Clamp: write ch0 target 0110_0000, one tick → `cur[0]` = 0110_0000 exactly, `settled_o[0]`=1.
- Top of range: ch5 `cur` at FFE0_0000, target FFFF_FFFF, one tick → FFFF_FFFF with no wrap to a small value.
- Tick overlap: three ticks during one scan → exactly one extra scan; `busy_o` high for 2×NUM_CH consecutive cycles.
- Reset mid-scan: assert `rst` at scan cycle 3 → `vol_o` is all 0100_0000 and `busy_o`=0 without waiting for a clock edge. The first tick after release scans from ch0.
- Soft mute (with macro): `mute_i[1]`=1, 4 ticks → `cur[1]`=0. Release mute, 4 ticks → `cur[1]` back to 0100_0000.

Source files
------------

// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mixer_pkg
// Brief    : Shared types and constants for the mixer volume ramp.
// Revision : 1.0
// ============================================================================
package mixer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } vol_state_e;

  localparam logic [31:0] VOL_UNITY = 32'h0100_0000;
  localparam logic [31:0] DEF_STEP  = 32'h0000_1000;

endpackage
`default_nettype wire

// File: rtl/vol_step.sv
`default_nettype none
// ============================================================================
// Module   : vol_step
// Brief    : Moves a gain one clamped step toward its effective target.
// Revision : 1.0
// ============================================================================
module vol_step #(
  parameter int VOL_WIDTH = 32
) (
  input  logic [VOL_WIDTH-1:0] i_cur,
  input  logic [VOL_WIDTH-1:0] i_eff,
  input  logic [VOL_WIDTH-1:0] i_step,
  output logic [VOL_WIDTH-1:0] o_next
);

  logic [VOL_WIDTH:0] w_up;
  logic [VOL_WIDTH:0] w_dn;

  // One extra bit so a step near either end of the range can never wrap.
  always_comb begin
    w_up   = {1'b0, i_cur} + {1'b0, i_step};
    w_dn   = {1'b0, i_cur} - {1'b0, i_step};
    o_next = i_cur;
    if (i_cur < i_eff) begin
      o_next = (w_up > {1'b0, i_eff}) ? i_eff : w_up[VOL_WIDTH-1:0];
    end else if (i_cur > i_eff) begin
      o_next = (w_dn[VOL_WIDTH] || (w_dn < {1'b0, i_eff})) ? i_eff : w_dn[VOL_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mixer_vol_ramp.sv
`default_nettype none
// ============================================================================
// Module   : mixer_vol_ramp
// Brief    : Per-channel gain slew toward programmable targets, one channel
//            per clock on each sample tick. Option: MIXER_VOL_RAMP_SOFTMUTE_EN.
// Revision : 1.0
// ============================================================================
module mixer_vol_ramp
  import mixer_pkg::*;
#(
  parameter int                   NUM_CH      = 8,
  parameter int                   NUM_CH_LOG2 = 3,
  parameter int                   VOL_WIDTH   = 32,
  parameter logic [VOL_WIDTH-1:0] STEP        = VOL_WIDTH'(DEF_STEP),
  parameter logic [VOL_WIDTH-1:0] RESET_VOL   = VOL_WIDTH'(VOL_UNITY)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_i,
  input  logic [NUM_CH_LOG2-1:0]        wr_ch_i,
  input  logic [VOL_WIDTH-1:0]          wr_vol_i,
  output logic                          wr_ack_o,
  input  logic                          tick_i,
  input  logic [NUM_CH-1:0]             mute_i,
  output logic [NUM_CH*VOL_WIDTH-1:0]   vol_o,
  output logic [NUM_CH-1:0]             settled_o,
  output logic                          busy_o
);

  logic [VOL_WIDTH-1:0]   r_tgt [NUM_CH];
  logic [VOL_WIDTH-1:0]   r_cur [NUM_CH];
  logic [VOL_WIDTH-1:0]   w_eff [NUM_CH];
  vol_state_e             r_state;
  logic [NUM_CH_LOG2-1:0] r_ch;
  logic                   r_pend;
  logic                   r_wr_ack;
  logic                   w_last;
  logic [VOL_WIDTH-1:0]   w_next;

`ifdef MIXER_VOL_RAMP_SOFTMUTE_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_eff
    assign w_eff[k] = mute_i[k] ? '0 : r_tgt[k];
  end
`else
  for (genvar k = 0; k < NUM_CH; k++) begin : g_eff
    assign w_eff[k] = r_tgt[k];
  end
  logic w_unused_mute;
  assign w_unused_mute = ^mute_i;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign vol_o[k*VOL_WIDTH +: VOL_WIDTH] = r_cur[k];
    assign settled_o[k]                    = (r_cur[k] == w_eff[k]);
  end

  assign w_last   = (r_ch == NUM_CH_LOG2'(NUM_CH - 1));
  assign busy_o   = (r_state == ST_SCAN);
  assign wr_ack_o = r_wr_ack;

  vol_step #(.VOL_WIDTH(VOL_WIDTH)) u_step (
    .i_cur  (r_cur[r_ch]),
    .i_eff  (w_eff[r_ch]),
    .i_step (STEP),
    .o_next (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) r_tgt[k] <= RESET_VOL;
      r_wr_ack <= 1'b0;
    end else begin
      r_wr_ack <= wr_i;
      if (wr_i) r_tgt[wr_ch_i] <= wr_vol_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) r_cur[k] <= RESET_VOL;
    end else if (r_state == ST_SCAN) begin
      r_cur[r_ch] <= w_next;
    end
  end

  // At most one tick is queued while scanning; a tick on the final cycle
  // restarts the scan directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tick_i) begin
            r_state <= ST_SCAN;
            r_ch    <= '0;
          end
        end
        ST_SCAN: begin
          if (w_last) begin
            r_ch   <= '0;
            r_pend <= 1'b0;
            if (!(r_pend || tick_i)) r_state <= ST_IDLE;
          end else begin
            r_ch <= r_ch + 1'b1;
            if (tick_i) r_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mixer_vol_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mixer_vol_ramp
// Brief    : Self-checking bench for mixer_vol_ramp against a gain model.
// Revision : 1.0
// ============================================================================
module tb_mixer_vol_ramp;

  localparam int          NCH  = 8;
  localparam int          LOG2 = 3;
  localparam int          W    = 32;
  localparam logic [31:0] STEP = 32'h0040_0000;
  localparam logic [31:0] RV   = 32'h0100_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr_i;
  logic [LOG2-1:0]    wr_ch_i;
  logic [W-1:0]       wr_vol_i;
  logic               wr_ack_o;
  logic               tick_i;
  logic [NCH-1:0]     mute_i;
  logic [NCH*W-1:0]   vol_o;
  logic [NCH-1:0]     settled_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_tgt [NCH];
  logic [31:0] m_cur [NCH];

  mixer_vol_ramp #(
    .NUM_CH(NCH), .NUM_CH_LOG2(LOG2), .VOL_WIDTH(W), .STEP(STEP), .RESET_VOL(RV)
  ) dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .wr_ch_i(wr_ch_i), .wr_vol_i(wr_vol_i),
    .wr_ack_o(wr_ack_o), .tick_i(tick_i), .mute_i(mute_i), .vol_o(vol_o),
    .settled_o(settled_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_eff(int k);
`ifdef MIXER_VOL_RAMP_SOFTMUTE_EN
    if (mute_i[k]) return 32'h0;
`endif
    return m_tgt[k];
  endfunction

  function automatic logic [31:0] m_next(logic [31:0] c, logic [31:0] e);
    longint lc = longint'(c);
    longint le = longint'(e);
    longint ls = longint'(STEP);
    if (lc < le) return 32'((lc + ls < le) ? lc + ls : le);
    if (lc > le) return 32'((lc - ls > le) ? lc - ls : le);
    return c;
  endfunction

  function automatic logic [NCH*W-1:0] exp_vol();
    logic [NCH*W-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = m_cur[k];
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_set();
    logic [NCH-1:0] s;
    for (int k = 0; k < NCH; k++) s[k] = (m_cur[k] == m_eff(k));
    return s;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_tgt[k] = RV;
      m_cur[k] = RV;
    end
  endfunction

  function automatic void model_tick();
    for (int k = 0; k < NCH; k++) m_cur[k] = m_next(m_cur[k], m_eff(k));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(int ch, logic [31:0] val);
    wr_i = 1'b1; wr_ch_i = LOG2'(ch); wr_vol_i = val;
    step();
    wr_i = 1'b0;
    m_tgt[ch] = val;
    checks++;
    if (wr_ack_o !== 1'b1) begin
      errors++; $display("FAIL wr_ack: got %b expected 1", wr_ack_o);
    end
    checks++;
    if (settled_o !== exp_set()) begin
      errors++; $display("FAIL wr_settled: got %b expected %b", settled_o, exp_set());
    end
  endtask

  task automatic run_tick(output int n);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      step();
    end
    model_tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (vol_o !== exp_vol()) begin
      errors++; $display("FAIL reset_vol: got %h expected %h", vol_o, exp_vol());
    end
    checks++;
    if (busy_o !== 1'b0 || wr_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy_ack: got %b%b expected 00", busy_o, wr_ack_o);
    end
    checks++;
    if (settled_o !== {NCH{1'b1}}) begin
      errors++; $display("FAIL reset_settled: got %b expected all ones", settled_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ramp_down();
    logic [31:0] exp2 [5];
    int n;
    exp2 = '{32'h00C0_0000, 32'h0080_0000, 32'h0040_0000, 32'h0, 32'h0};
    do_write(2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      run_tick(n);
      checks++;
      if (n != NCH) begin
        errors++; $display("FAIL ramp_busy_len: got %0d expected %0d", n, NCH);
      end
      checks++;
      if (vol_o[2*W +: W] !== exp2[i]) begin
        errors++; $display("FAIL ramp_ch2 tick%0d: got %h expected %h", i, vol_o[2*W +: W], exp2[i]);
      end
      checks++;
      if (vol_o !== exp_vol()) begin
        errors++; $display("FAIL ramp_all: got %h expected %h", vol_o, exp_vol());
      end
      checks++;
      if (settled_o[2] !== (i >= 3)) begin
        errors++; $display("FAIL ramp_settled2 tick%0d: got %b expected %b", i, settled_o[2], i >= 3);
      end
    end
  endtask

  task automatic test_clamp();
    int n;
    do_write(0, 32'h0110_0000);
    run_tick(n);
    checks++;
    if (vol_o[W-1:0] !== 32'h0110_0000 || settled_o[0] !== 1'b1) begin
      errors++; $display("FAIL clamp: got %h/%b expected 01100000/1", vol_o[W-1:0], settled_o[0]);
    end
  endtask

  task automatic test_mute();
    int n;
    mute_i = 8'h02;
    for (int i = 0; i < 4; i++) run_tick(n);
    checks++;
    if (vol_o !== exp_vol()) begin
      errors++; $display("FAIL mute_all: got %h expected %h", vol_o, exp_vol());
    end
`ifdef MIXER_VOL_RAMP_SOFTMUTE_EN
    checks++;
    if (vol_o[W +: W] !== 32'h0 || settled_o[1] !== 1'b1) begin
      errors++; $display("FAIL mute_down: got %h/%b expected 00000000/1", vol_o[W +: W], settled_o[1]);
    end
`else
    checks++;
    if (vol_o[W +: W] !== RV) begin
      errors++; $display("FAIL mute_ignored: got %h expected %h", vol_o[W +: W], RV);
    end
`endif
    mute_i = '0;
    for (int i = 0; i < 4; i++) run_tick(n);
    checks++;
    if (vol_o[W +: W] !== RV || settled_o[1] !== 1'b1) begin
      errors++; $display("FAIL unmute: got %h/%b expected %h/1", vol_o[W +: W], settled_o[1], RV);
    end
  endtask

  task automatic test_top();
    int n;
    int t;
    do_write(5, 32'hFFE0_0000);
    t = 0;
    while (settled_o[5] !== 1'b1 && t < 1100) begin
      run_tick(n);
      t++;
    end
    checks++;
    if (vol_o[5*W +: W] !== 32'hFFE0_0000) begin
      errors++; $display("FAIL top_reach: got %h expected ffe00000 after %0d ticks", vol_o[5*W +: W], t);
    end
    do_write(5, 32'hFFFF_FFFF);
    run_tick(n);
    checks++;
    if (vol_o[5*W +: W] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL top_nowrap: got %h expected ffffffff", vol_o[5*W +: W]);
    end
    checks++;
    if (vol_o !== exp_vol()) begin
      errors++; $display("FAIL top_all: got %h expected %h", vol_o, exp_vol());
    end
  endtask

  task automatic test_timing();
    logic [31:0]      nxt [NCH];
    logic [NCH*W-1:0] e;
    for (int k = 0; k < NCH; k++) do_write(k, $urandom_range(32'h0300_0000, 0));
    for (int k = 0; k < NCH; k++) nxt[k] = m_next(m_cur[k], m_eff(k));
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    for (int j = 1; j <= NCH + 1; j++) begin
      for (int k = 0; k < NCH; k++) e[k*W +: W] = (k <= j - 2) ? nxt[k] : m_cur[k];
      checks++;
      if (vol_o !== e || busy_o !== (j <= NCH)) begin
        errors++; $display("FAIL timing cyc%0d: got %h busy %b expected %h busy %b", j, vol_o, busy_o, e, j <= NCH);
      end
      if (j <= NCH) step();
    end
    model_tick();
  endtask

  task automatic test_overlap(int variant);
    int n;
    for (int k = 0; k < NCH; k++) do_write(k, $urandom_range(32'h0300_0000, 0));
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      if (variant == 0) tick_i = (n == 2 || n == 5 || n == 8);
      else              tick_i = (n == 8);
      step();
      tick_i = 1'b0;
    end
    model_tick();
    model_tick();
    checks++;
    if (n != 2 * NCH) begin
      errors++; $display("FAIL overlap%0d_busy: got %0d expected %0d", variant, n, 2 * NCH);
    end
    checks++;
    if (vol_o !== exp_vol()) begin
      errors++; $display("FAIL overlap%0d_vol: got %h expected %h", variant, vol_o, exp_vol());
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] old;
    logic [31:0] want;
    int n;
    old = m_cur[3];
    do_write(3, (old < 32'h8000_0000) ? old + 4 * STEP : old - 4 * STEP);
    want = m_next(old, m_eff(3));
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      if (n == 4) begin
        wr_i = 1'b1; wr_ch_i = 3'd3; wr_vol_i = old;
      end
      step();
      wr_i = 1'b0;
    end
    model_tick();
    m_tgt[3] = old;
    checks++;
    if (vol_o[3*W +: W] !== want || settled_o[3] !== 1'b0) begin
      errors++; $display("FAIL same_cycle_old_tgt: got %h/%b expected %h/0", vol_o[3*W +: W], settled_o[3], want);
    end
    run_tick(n);
    checks++;
    if (vol_o[3*W +: W] !== old || vol_o !== exp_vol()) begin
      errors++; $display("FAIL same_cycle_new_tgt: got %h expected %h", vol_o[3*W +: W], old);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_write(0, 32'h0);
    do_write(7, 32'h0);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (vol_o !== exp_vol() || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %h busy %b expected %h busy 0", vol_o, busy_o, exp_vol());
    end
    checks++;
    if (settled_o !== {NCH{1'b1}}) begin
      errors++; $display("FAIL reset_mid_settled: got %b expected all ones", settled_o);
    end
    step();
    #2 rst = 1'b0;
    step();
    do_write(0, 32'h0);
    do_write(7, 32'h0);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step();
    checks++;
    if (vol_o[W-1:0] !== RV - STEP || vol_o[7*W +: W] !== RV) begin
      errors++; $display("FAIL reset_rescan_ch0: got %h/%h expected %h/%h", vol_o[W-1:0], vol_o[7*W +: W], RV - STEP, RV);
    end
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      step();
    end
    model_tick();
    checks++;
    if (vol_o !== exp_vol()) begin
      errors++; $display("FAIL reset_rescan_all: got %h expected %h", vol_o, exp_vol());
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(3, 0)); w++) begin
        if ($urandom_range(1, 0) == 1) do_write(int'($urandom_range(NCH - 1, 0)), $urandom);
        else do_write(int'($urandom_range(NCH - 1, 0)), m_cur[0] + $urandom_range(32'h0100_0000, 0));
      end
      mute_i = NCH'($urandom);
      run_tick(n);
      checks++;
      if (n != NCH || vol_o !== exp_vol()) begin
        errors++; $display("FAIL random it%0d: got %h busy %0d expected %h busy %0d", it, vol_o, n, exp_vol(), NCH);
      end
      checks++;
      if (settled_o !== exp_set()) begin
        errors++; $display("FAIL random_settled it%0d: got %b expected %b", it, settled_o, exp_set());
      end
    end
    mute_i = '0;
  endtask

  initial begin
    rst = 1'b0; wr_i = 1'b0; wr_ch_i = '0; wr_vol_i = '0; tick_i = 1'b0; mute_i = '0;
    model_reset();
    test_reset();
    test_ramp_down();
    test_clamp();
    test_mute();
    test_top();
    test_timing();
    test_overlap(0);
    test_overlap(1);
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
